// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase controller: state codes, BCD pair, BCD helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2,
        ST_FLASH   = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    localparam bcd_t BCD_ZERO = 8'h00;
    localparam bcd_t BCD_ONE  = 8'h01;

    // Convert an elaboration-time constant (0..99) to a BCD pair.
    function automatic bcd_t to_bcd(input int unsigned v);
        bcd_t b;
        b.tens = 4'((v / 10) % 10);
        b.ones = 4'(v % 10);
        return b;
    endfunction

    // One-second decrement of a BCD pair; callers never pass 00.
    function automatic bcd_t bcd_dec(input bcd_t b);
        bcd_t r;
        if (b.ones == 4'd0) begin
            r.tens = b.tens - 4'd1;
            r.ones = 4'd9;
        end else begin
            r.tens = b.tens;
            r.ones = b.ones - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 and pulses tick during the cycle the count sits at DIV-1.
// Latency: tick is a flop output aligned with the DIV-1 count; first pulse DIV cycles after reset.
// Backpressure: none; free-running while out of reset.
module tick_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic clk_50M,
    input  logic reset_btn,
    output logic tick
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;

    // Wrap the count at DIV-1.
    always_comb begin
        cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    end

    // Count register; tick is registered so it lines up with the DIV-1 count.
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CW'(DIV - 1));
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller with BCD countdown, demand skip, one-shot extension, night flash.
// Latency: FSM moves only on tick cycles; every output is registered one cycle behind the FSM state.
// Backpressure: none; demand and night are level inputs sampled on tick cycles.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES = 2,
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int GREEN_S    = 30,
    parameter int YELLOW_S   = 3,
    parameter int ALLRED_S   = 1,
    parameter int EXTEND_S   = 10
) (
    input  logic                  clk_50M,
    input  logic                  reset_btn,
    input  logic [NUM_PHASES-1:0] demand,
    input  logic                  night,
    output logic [NUM_PHASES-1:0] lamp_r,
    output logic [NUM_PHASES-1:0] lamp_y,
    output logic [NUM_PHASES-1:0] lamp_g,
    output logic [1:0]            phase,
    output logic [1:0]            state,
    output logic [3:0]            time_tens,
    output logic [3:0]            time_ones,
    output logic                  tick
);
    import traffic_pkg::*;

    localparam int         DIV        = CLK_HZ / TICK_HZ;
    localparam bcd_t       GREEN_BCD  = to_bcd(GREEN_S);
    localparam bcd_t       YELLOW_BCD = to_bcd(YELLOW_S);
    localparam bcd_t       ALLRED_BCD = to_bcd(ALLRED_S);
    localparam bcd_t       EXTEND_BCD = to_bcd(EXTEND_S);
    localparam logic [1:0] LAST_PHASE = 2'(NUM_PHASES - 1);

    state_e                state_q, state_d;
    logic [1:0]            phase_q, phase_d;
    bcd_t                  cnt_q, cnt_d;
    logic                  ext_q, ext_d;
    logic                  flash_q, flash_d;

    logic [NUM_PHASES-1:0] one_hot;
    logic [1:0]            next_phase;
    logic                  found;
    int                    idx;
    logic                  is_one;
    logic                  extend_ok;

    logic [NUM_PHASES-1:0] lamp_r_d, lamp_y_d, lamp_g_d;
    logic [NUM_PHASES-1:0] lamp_r_q, lamp_y_q, lamp_g_q;
    bcd_t                  time_d, time_q;
    logic [1:0]            out_state_q, out_phase_q;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk_50M   (clk_50M),
        .reset_btn (reset_btn),
        .tick      (tick)
    );

    // Round-robin search for the next demanded phase, starting after the current one.
    always_comb begin
        next_phase = 2'((int'(phase_q) + 1) % NUM_PHASES);
        found      = 1'b0;
        idx        = 0;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            idx = (int'(phase_q) + i) % NUM_PHASES;
            if (!found && demand[idx]) begin
                found      = 1'b1;
                next_phase = 2'(idx);
            end
        end
    end

    // Decode helpers: current phase as one-hot, countdown at 01, extension eligibility.
    always_comb begin
        one_hot   = NUM_PHASES'(1) << phase_q;
        is_one    = (cnt_q == BCD_ONE);
        extend_ok = |(demand & one_hot) && ((demand & ~one_hot) == '0) && !night && !ext_q;
    end

    // State register.
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state_q <= ST_ALL_RED;
            phase_q <= LAST_PHASE;
            cnt_q   <= ALLRED_BCD;
            ext_q   <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            flash_q <= flash_d;
        end
    end

    // Next-state logic; nothing moves except on tick cycles.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        flash_d = flash_q;
        if (tick) begin
            case (state_q)
                ST_ALL_RED: begin
                    if (!is_one) begin
                        cnt_d = bcd_dec(cnt_q);
                    end else if (night) begin
                        // Lamps come on in the first flash half-period.
                        state_d = ST_FLASH;
                        cnt_d   = BCD_ZERO;
                        flash_d = 1'b1;
                    end else begin
                        state_d = ST_GREEN;
                        phase_d = next_phase;
                        cnt_d   = GREEN_BCD;
                        ext_d   = 1'b0;
                    end
                end
                ST_GREEN: begin
                    if (!is_one) begin
                        cnt_d = bcd_dec(cnt_q);
                    end else if (extend_ok) begin
                        cnt_d = EXTEND_BCD;
                        ext_d = 1'b1;
                    end else begin
                        state_d = ST_YELLOW;
                        cnt_d   = YELLOW_BCD;
                    end
                end
                ST_YELLOW: begin
                    if (!is_one) begin
                        cnt_d = bcd_dec(cnt_q);
                    end else begin
                        state_d = ST_ALL_RED;
                        cnt_d   = ALLRED_BCD;
                    end
                end
                ST_FLASH: begin
                    flash_d = ~flash_q;
                    if (!night) begin
                        state_d = ST_ALL_RED;
                        cnt_d   = ALLRED_BCD;
                    end
                end
                default: state_d = ST_ALL_RED;
            endcase
        end
    end

    // Lamp and display decode from the current state.
    always_comb begin
        lamp_r_d = '0;
        lamp_y_d = '0;
        lamp_g_d = '0;
        time_d   = cnt_q;
        case (state_q)
            ST_ALL_RED: lamp_r_d = '1;
            ST_GREEN: begin
                lamp_g_d = one_hot;
                lamp_r_d = ~one_hot;
            end
            ST_YELLOW: begin
                lamp_y_d = one_hot;
                lamp_r_d = ~one_hot;
            end
            ST_FLASH: begin
                lamp_y_d = {NUM_PHASES{flash_q}};
                time_d   = BCD_ZERO;
            end
            default: lamp_r_d = '1;
        endcase
    end

    // Output registers; reset drives the safe all-red picture directly.
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            lamp_r_q    <= '1;
            lamp_y_q    <= '0;
            lamp_g_q    <= '0;
            time_q      <= ALLRED_BCD;
            out_state_q <= ST_ALL_RED;
            out_phase_q <= LAST_PHASE;
        end else begin
            lamp_r_q    <= lamp_r_d;
            lamp_y_q    <= lamp_y_d;
            lamp_g_q    <= lamp_g_d;
            time_q      <= time_d;
            out_state_q <= state_q;
            out_phase_q <= phase_q;
        end
    end

    assign lamp_r    = lamp_r_q;
    assign lamp_y    = lamp_y_q;
    assign lamp_g    = lamp_g_q;
    assign time_tens = time_q.tens;
    assign time_ones = time_q.ones;
    assign state     = out_state_q;
    assign phase     = out_phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with a scoreboard of expected display snapshots.
// Latency: each snapshot is sampled two cycles after the tick that caused it.
// Backpressure: not applicable.
module tb_traffic_phase_ctrl;

    localparam int NP = 3;

    logic          clk_50M = 1'b0;
    logic          reset_btn;
    logic [NP-1:0] demand;
    logic          night;
    logic [NP-1:0] lamp_r, lamp_y, lamp_g;
    logic [1:0]    phase, state;
    logic [3:0]    time_tens, time_ones;
    logic          tick;

    always #5 clk_50M = ~clk_50M;

    traffic_phase_ctrl #(
        .NUM_PHASES (NP),
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .GREEN_S    (5),
        .YELLOW_S   (2),
        .ALLRED_S   (1),
        .EXTEND_S   (3)
    ) dut (
        .clk_50M   (clk_50M),
        .reset_btn (reset_btn),
        .demand    (demand),
        .night     (night),
        .lamp_r    (lamp_r),
        .lamp_y    (lamp_y),
        .lamp_g    (lamp_g),
        .phase     (phase),
        .state     (state),
        .time_tens (time_tens),
        .time_ones (time_ones),
        .tick      (tick)
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [1:0] ph;
        logic [3:0] tt;
        logic [3:0] to;
        logic       fl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Expected lamps {r,y,g} for a given state/phase/flash bit.
    function automatic logic [8:0] lamps(input logic [1:0] st, input logic [1:0] ph, input logic fl);
        logic [2:0] oh;
        oh = 3'b001 << ph;
        case (st)
            2'd0:    return {3'b111, 3'b000, 3'b000};
            2'd1:    return {~oh, 3'b000, oh};
            2'd2:    return {~oh, oh, 3'b000};
            default: return {3'b000, {3{fl}}, 3'b000};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic [1:0] ph,
                        input logic [3:0] tt, input logic [3:0] to, input logic fl);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ph  = ph;
        e.tt  = tt;
        e.to  = to;
        e.fl  = fl;
        sb.push_back(e);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk_50M);
            n++;
        end while (tick !== 1'b1 && n < 40);
        if (tick !== 1'b1) begin
            checks++;
            $error("FAIL tick_timeout: no tick within %0d cycles", n);
        end
    endtask

    // Wait for a tick, let FSM and output registers settle, compare against the oldest expectation.
    // gap > 0 also checks the number of negedges waited for the tick.
    task automatic step(input int gap);
        int   n;
        exp_t e;
        wait_tick(n);
        if (gap > 0) check("tick_gap", 32'(n), 32'(gap));
        @(negedge clk_50M);
        @(negedge clk_50M);
        if (sb.size() == 0) begin
            checks++;
            $error("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check(e.tag,
                  32'({state, phase, time_tens, time_ones, lamp_r, lamp_y, lamp_g}),
                  32'({e.st, e.ph, e.tt, e.to, lamps(e.st, e.ph, e.fl)}));
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) step(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        demand    = '0;
        night     = 1'b0;
        reset_btn = 1'b1;
        repeat (3) @(posedge clk_50M);
        @(negedge clk_50M);
        check("reset_state",
              32'({state, phase, time_tens, time_ones, lamp_r, lamp_y, lamp_g, tick}),
              32'({2'd0, 2'd2, 4'd0, 4'd1, 9'b111_000_000, 1'b0}));
        reset_btn = 1'b0;

        // No demand: plain rotation 0 -> 1. First tick lands in the tenth cycle after the
        // last reset edge (the release negedge is the first), later ticks every 10 cycles.
        push("a_g0_05", 2'd1, 2'd0, 4'd0, 4'd5, 1'b0);
        push("a_g0_04", 2'd1, 2'd0, 4'd0, 4'd4, 1'b0);
        push("a_g0_03", 2'd1, 2'd0, 4'd0, 4'd3, 1'b0);
        push("a_g0_02", 2'd1, 2'd0, 4'd0, 4'd2, 1'b0);
        push("a_g0_01", 2'd1, 2'd0, 4'd0, 4'd1, 1'b0);
        push("a_y0_02", 2'd2, 2'd0, 4'd0, 4'd2, 1'b0);
        push("a_y0_01", 2'd2, 2'd0, 4'd0, 4'd1, 1'b0);
        push("a_ar0_01", 2'd0, 2'd0, 4'd0, 4'd1, 1'b0);
        push("a_g1_05", 2'd1, 2'd1, 4'd0, 4'd5, 1'b0);
        step(9);
        step(8);
        drain();

        // Demand on phase 0 only while phase 1 is green: phase 2 is skipped.
        demand = 3'b001;
        push("b_g1_04", 2'd1, 2'd1, 4'd0, 4'd4, 1'b0);
        push("b_g1_03", 2'd1, 2'd1, 4'd0, 4'd3, 1'b0);
        push("b_g1_02", 2'd1, 2'd1, 4'd0, 4'd2, 1'b0);
        push("b_g1_01", 2'd1, 2'd1, 4'd0, 4'd1, 1'b0);
        push("b_y1_02", 2'd2, 2'd1, 4'd0, 4'd2, 1'b0);
        push("b_y1_01", 2'd2, 2'd1, 4'd0, 4'd1, 1'b0);
        push("b_ar1_01", 2'd0, 2'd1, 4'd0, 4'd1, 1'b0);
        push("b_g0_05", 2'd1, 2'd0, 4'd0, 4'd5, 1'b0);
        drain();

        // Sole demand on the green phase: exactly one extension of 3 s.
        push("c_g0_04", 2'd1, 2'd0, 4'd0, 4'd4, 1'b0);
        push("c_g0_03", 2'd1, 2'd0, 4'd0, 4'd3, 1'b0);
        push("c_g0_02", 2'd1, 2'd0, 4'd0, 4'd2, 1'b0);
        push("c_g0_01", 2'd1, 2'd0, 4'd0, 4'd1, 1'b0);
        push("c_ext_03", 2'd1, 2'd0, 4'd0, 4'd3, 1'b0);
        push("c_ext_02", 2'd1, 2'd0, 4'd0, 4'd2, 1'b0);
        push("c_ext_01", 2'd1, 2'd0, 4'd0, 4'd1, 1'b0);
        push("c_y0_02", 2'd2, 2'd0, 4'd0, 4'd2, 1'b0);
        drain();
        demand = 3'b100;
        push("c_y0_01", 2'd2, 2'd0, 4'd0, 4'd1, 1'b0);
        push("c_ar0_01", 2'd0, 2'd0, 4'd0, 4'd1, 1'b0);
        push("c_g2_05", 2'd1, 2'd2, 4'd0, 4'd5, 1'b0);
        drain();

        // Own demand plus another phase's demand at expiry: no extension.
        demand = 3'b101;
        push("d_g2_04", 2'd1, 2'd2, 4'd0, 4'd4, 1'b0);
        push("d_g2_03", 2'd1, 2'd2, 4'd0, 4'd3, 1'b0);
        push("d_g2_02", 2'd1, 2'd2, 4'd0, 4'd2, 1'b0);
        push("d_g2_01", 2'd1, 2'd2, 4'd0, 4'd1, 1'b0);
        push("d_y2_02", 2'd2, 2'd2, 4'd0, 4'd2, 1'b0);
        push("d_y2_01", 2'd2, 2'd2, 4'd0, 4'd1, 1'b0);
        push("d_ar2_01", 2'd0, 2'd2, 4'd0, 4'd1, 1'b0);
        push("d_g0_05", 2'd1, 2'd0, 4'd0, 4'd5, 1'b0);
        drain();

        // Night raised mid-green: green completes, then flash, then recovery.
        demand = 3'b000;
        push("e_g0_04", 2'd1, 2'd0, 4'd0, 4'd4, 1'b0);
        push("e_g0_03", 2'd1, 2'd0, 4'd0, 4'd3, 1'b0);
        drain();
        night = 1'b1;
        push("e_g0_02", 2'd1, 2'd0, 4'd0, 4'd2, 1'b0);
        push("e_g0_01", 2'd1, 2'd0, 4'd0, 4'd1, 1'b0);
        push("e_y0_02", 2'd2, 2'd0, 4'd0, 4'd2, 1'b0);
        push("e_y0_01", 2'd2, 2'd0, 4'd0, 4'd1, 1'b0);
        push("e_ar0_01", 2'd0, 2'd0, 4'd0, 4'd1, 1'b0);
        push("e_flash_on", 2'd3, 2'd0, 4'd0, 4'd0, 1'b1);
        push("e_flash_off", 2'd3, 2'd0, 4'd0, 4'd0, 1'b0);
        push("e_flash_on2", 2'd3, 2'd0, 4'd0, 4'd0, 1'b1);
        drain();
        night = 1'b0;
        push("e_ar0_exit", 2'd0, 2'd0, 4'd0, 4'd1, 1'b0);
        push("e_g1_05", 2'd1, 2'd1, 4'd0, 4'd5, 1'b0);
        drain();

        // Reset pulse during yellow 02.
        push("f_g1_04", 2'd1, 2'd1, 4'd0, 4'd4, 1'b0);
        push("f_g1_03", 2'd1, 2'd1, 4'd0, 4'd3, 1'b0);
        push("f_g1_02", 2'd1, 2'd1, 4'd0, 4'd2, 1'b0);
        push("f_g1_01", 2'd1, 2'd1, 4'd0, 4'd1, 1'b0);
        push("f_y1_02", 2'd2, 2'd1, 4'd0, 4'd2, 1'b0);
        drain();
        reset_btn = 1'b1;
        @(negedge clk_50M);
        check("reset_mid",
              32'({state, phase, time_tens, time_ones, lamp_r, lamp_y, lamp_g, tick}),
              32'({2'd0, 2'd2, 4'd0, 4'd1, 9'b111_000_000, 1'b0}));
        reset_btn = 1'b0;
        push("f_g0_05", 2'd1, 2'd0, 4'd0, 4'd5, 1'b0);
        step(9);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
